// File: rtl/ro_puf_response_gen.sv
// Ring-oscillator PUF response generator: pairwise edge-count race per bit.
// Optional per-bit tie flags when ROPUF_TIE_DETECT_EN is defined.
module ro_puf_response_gen #(
  parameter int N_RO      = 8,
  parameter int SEL_W     = $clog2(N_RO),
  parameter int CNT_W     = 16,
  parameter int WINDOW    = 1024,
  parameter int RESP_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_RO-1:0]      ro_in,
  input  logic                 start,
  input  logic [SEL_W-1:0]     challenge,
  output logic [N_RO-1:0]      ro_enable,
  output logic                 busy,
  output logic                 done,
`ifdef ROPUF_TIE_DETECT_EN
  output logic [RESP_BITS-1:0] tie,
`endif
  output logic [RESP_BITS-1:0] response
);

  localparam int KW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int TW = $clog2(WINDOW + 4) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_COUNT, S_CMP, S_DONE
  } state_t;

  state_t               r_state;
  logic [SEL_W-1:0]     r_base;
  logic [KW-1:0]        r_k;
  logic [TW-1:0]        r_tmr;
  logic [CNT_W-1:0]     r_cnt_a;
  logic [CNT_W-1:0]     r_cnt_b;
  logic [RESP_BITS-1:0] r_work;
  logic [RESP_BITS-1:0] r_resp;
  logic [N_RO-1:0]      r_en;
  logic                 r_busy;
  logic                 r_done;
  logic [N_RO-1:0]      r_s1, r_s2, r_s3;

  logic [N_RO-1:0]      w_edge;
  logic [N_RO-1:0]      w_mask_a;
  logic [N_RO-1:0]      w_mask_b;
  logic                 w_ea;
  logic                 w_eb;
  logic                 w_last;
  logic [RESP_BITS-1:0] w_work_nx;

  function automatic logic [N_RO-1:0] chan_mask(
    input logic [SEL_W-1:0] b,
    input logic [KW-1:0]    k,
    input logic             second
  );
    int unsigned idx;
    idx = (32'(b) + 32'(k) * 2 + 32'(second)) % N_RO;
    return N_RO'(1) << idx;
  endfunction

  function automatic logic [N_RO-1:0] pair_mask(
    input logic [SEL_W-1:0] b,
    input logic [KW-1:0]    k
  );
    return chan_mask(b, k, 1'b0) | chan_mask(b, k, 1'b1);
  endfunction

  assign w_edge   = r_s2 & ~r_s3;
  assign w_mask_a = chan_mask(r_base, r_k, 1'b0);
  assign w_mask_b = chan_mask(r_base, r_k, 1'b1);
  assign w_ea     = |(w_edge & w_mask_a);
  assign w_eb     = |(w_edge & w_mask_b);
  assign w_last   = (r_k == KW'(RESP_BITS - 1));

  always_comb begin
    w_work_nx      = r_work;
    w_work_nx[r_k] = (r_cnt_a > r_cnt_b);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= ro_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

`ifdef ROPUF_TIE_DETECT_EN
  logic [RESP_BITS-1:0] r_tiew;
  logic [RESP_BITS-1:0] r_tie;
  logic [RESP_BITS-1:0] w_tie_nx;

  always_comb begin
    w_tie_nx      = r_tiew;
    w_tie_nx[r_k] = (r_cnt_a == r_cnt_b);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tiew <= '0;
      r_tie  <= '0;
    end else if (r_state == S_CMP) begin
      r_tiew <= w_tie_nx;
      if (w_last) r_tie <= w_tie_nx;
    end
  end

  assign tie = r_tie;
`endif

  // Outputs are registered so they change on the edge entering each state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_k     <= '0;
      r_tmr   <= '0;
      r_cnt_a <= '0;
      r_cnt_b <= '0;
      r_work  <= '0;
      r_resp  <= '0;
      r_en    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base  <= challenge;
            r_k     <= '0;
            r_tmr   <= '0;
            r_busy  <= 1'b1;
            r_en    <= pair_mask(challenge, '0);
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_cnt_a <= '0;
          r_cnt_b <= '0;
          if (r_tmr == TW'(3)) begin
            r_tmr   <= '0;
            r_state <= S_COUNT;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        S_COUNT: begin
          if (w_ea && r_cnt_a != '1) r_cnt_a <= r_cnt_a + 1'b1;
          if (w_eb && r_cnt_b != '1) r_cnt_b <= r_cnt_b + 1'b1;
          if (r_tmr == TW'(WINDOW - 1)) begin
            r_tmr   <= '0;
            r_en    <= '0;
            r_state <= S_CMP;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        S_CMP: begin
          r_work <= w_work_nx;
          if (w_last) begin
            r_resp  <= w_work_nx;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_k     <= r_k + 1'b1;
            r_en    <= pair_mask(r_base, r_k + 1'b1);
            r_state <= S_SETUP;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ro_enable = r_en;
  assign busy      = r_busy;
  assign done      = r_done;
  assign response  = r_resp;

endmodule

// File: tb/tb_ro_puf_response_gen.sv
// Directed bench for ro_puf_response_gen (N_RO=8, WINDOW=64, RESP_BITS=4).
// Oscillators are square waves with half-periods in whole clk cycles.
module tb_ro_puf_response_gen;

  localparam int LAT = 4 * (64 + 5) + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] ro_in = '0;
  logic       start = 1'b0;
  logic [2:0] challenge = '0;
  logic [7:0] ro_enable;
  logic       busy;
  logic       done;
  logic [3:0] response;
`ifdef ROPUF_TIE_DETECT_EN
  logic [3:0] tie;
`endif

  int total = 0;
  int bad   = 0;
  int hp [8] = '{default: 3};
  int tick = 0;

  ro_puf_response_gen #(
    .N_RO(8), .SEL_W(3), .CNT_W(16), .WINDOW(64), .RESP_BITS(4)
  ) dut (
    .clk(clk), .rst(rst), .ro_in(ro_in), .start(start),
    .challenge(challenge), .ro_enable(ro_enable), .busy(busy),
    .done(done),
`ifdef ROPUF_TIE_DETECT_EN
    .tie(tie),
`endif
    .response(response)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    tick = tick + 1;
    for (int i = 0; i < 8; i++)
      ro_in[i] = ((tick / hp[i]) % 2) == 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Starts a run; returns at the negedge where done is seen (lat=0 on timeout).
  task automatic run(input logic [2:0] ch, input int pulse_at,
                     output int lat, output logic [3:0] resp,
                     output logic [7:0] en0, output logic [7:0] en1,
                     output logic b1, output logic [3:0] tv);
    lat = 0; resp = 'x; en0 = 'x; en1 = 'x; b1 = 1'b0; tv = '0;
    @(negedge clk);
    start = 1'b1;
    challenge = ch;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0;
        en0 = ro_enable;
        b1 = busy;
      end
      if (n == 70) en1 = ro_enable;
      if (n == pulse_at) begin
        start = 1'b1;
        challenge = 3'd7;
      end
      if (n == pulse_at + 1) start = 1'b0;
      if (done) begin
        lat = n;
        resp = response;
`ifdef ROPUF_TIE_DETECT_EN
        tv = tie;
`endif
        break;
      end
    end
  endtask

  task automatic set_hp(input logic [7:0][3:0] h);
    for (int i = 0; i < 8; i++) hp[i] = int'(h[i]);
    repeat (20) @(negedge clk);
  endtask

  typedef struct {
    logic [2:0]      ch;
    logic [7:0][3:0] hps;
    logic [3:0]      resp;
    logic [3:0]      tie;
    logic [7:0]      en0;
    logic [7:0]      en1;
  } vec_t;

  vec_t tv [3];

  initial begin
    int lat;
    int ndone;
    logic [3:0] r;
    logic [3:0] tq;
    logic [7:0] e0, e1;
    logic b1;

    tv[0] = '{3'd0, {4'd5,4'd3,4'd5,4'd3,4'd5,4'd3,4'd5,4'd3},
              4'b1111, 4'b0000, 8'h03, 8'h0C};
    tv[1] = '{3'd7, {4'd3,4'd3,4'd5,4'd5,4'd3,4'd3,4'd5,4'd5},
              4'b0101, 4'b0000, 8'h81, 8'h06};
    tv[2] = '{3'd0, {4'd4,4'd4,4'd3,4'd5,4'd5,4'd3,4'd4,4'd4},
              4'b0010, 4'b1001, 8'h03, 8'h0C};

    // Reset with start held high
    rst = 1'b0;
    start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_resp", response, 0);
    chk("rst_en", ro_enable, 0);
    start = 1'b0;
    rst = 1'b1;

    for (int v = 0; v < 3; v++) begin
      set_hp(tv[v].hps);
      run(tv[v].ch, -10, lat, r, e0, e1, b1, tq);
      chk($sformatf("v%0d_lat", v), lat, LAT);
      chk($sformatf("v%0d_resp", v), r, tv[v].resp);
      chk($sformatf("v%0d_en0", v), e0, tv[v].en0);
      chk($sformatf("v%0d_en1", v), e1, tv[v].en1);
      chk($sformatf("v%0d_busy", v), b1, 1);
`ifdef ROPUF_TIE_DETECT_EN
      chk($sformatf("v%0d_tie", v), tq, tv[v].tie);
`endif
      @(negedge clk);
      chk($sformatf("v%0d_busy_after", v), busy, 0);
    end

    // Start pulses in COUNT and in the DONE cycle are ignored
    set_hp(tv[0].hps);
    run(3'd0, 20, lat, r, e0, e1, b1, tq);
    chk("hs_lat", lat, LAT);
    chk("hs_resp", r, 4'b1111);
    start = 1'b1;
    challenge = 3'd7;
    @(negedge clk);
    start = 1'b0;
    chk("hs_busy_after", busy, 0);
    chk("hs_resp_hold", response, 4'b1111);
    @(negedge clk);
    chk("hs_not_accepted", busy, 0);
    run(3'd2, -10, lat, r, e0, e1, b1, tq);
    chk("hs_next_lat", lat, LAT);
    chk("hs_next_resp", r, 4'b1111);
    chk("hs_next_en0", e0, 8'h0C);

    // Reset during COUNT of bit 2
    @(negedge clk);
    start = 1'b1;
    challenge = 3'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (159) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("mr_busy", busy, 0);
    chk("mr_en", ro_enable, 0);
    chk("mr_resp", response, 0);
    ndone = 0;
    for (int n = 0; n < 300; n++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("mr_no_done", ndone, 0);
    set_hp(tv[1].hps);
    run(3'd7, -10, lat, r, e0, e1, b1, tq);
    chk("mr_fresh_lat", lat, LAT);
    chk("mr_fresh_resp", r, 4'b0101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ro_puf_response_gen.md
# ro_puf_response_gen

Parametrised ring-oscillator PUF response generator. It replaces the fixed 8-way oscillator mux with a sequencer that measures N_RO oscillator outputs pairwise. For each pair it counts rising edges over a fixed window, compares the two counts and emits a multi-bit response. It sits between the oscillator bank, which it enables per pair, and the key/ID logic, which issues a challenge and receives the response with a start/done handshake.

## Interface
- N_RO, 8: number of ring-oscillator channels; must be ≥2.
- SEL_W, $clog2(N_RO): challenge width.
- CNT_W, 16: edge-counter width.
- WINDOW, 1024: measurement window, in clk cycles; must be ≥1.
- RESP_BITS, 4: response bits per challenge; must be ≥1.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- ro_in  in  N_RO  raw oscillator outputs, asynchronous to clk.
- start  in  1  request; accepted only when busy=0.
- challenge  in  SEL_W  base oscillator index; captured when start is accepted.
- ro_enable  out  N_RO  per-oscillator enable; only the pair under test is high.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when response is valid.
- response  out  RESP_BITS  last completed response; holds until the next done.
- tie  out  RESP_BITS  per-bit equal-count flag; present only with ROPUF_TIE_DETECT_EN.

## Operation
- Each ro_in bit passes a 2-FF synchronizer and a third flop for rising-edge detection. An edge is a synchronized 0→1 transition.
- FSM states are IDLE, SETUP, COUNT, COMPARE and DONE.
- IDLE:
  - start=1 latches challenge into base.
  - The bit index k is cleared to 0.
  - The next state is SETUP.
- SETUP, 4 cycles:
  - Pair indices are a=(base+2k) mod N_RO and b=(base+2k+1) mod N_RO. Wrap-around is required.
  - ro_enable[a] and ro_enable[b] are set to 1 and every other enable bit is 0.
  - Both counters are cleared. Edges are ignored while the synchronizers flush.
- COUNT, WINDOW cycles:
  - cnt_a increments on each edge of channel a, and cnt_b on each edge of channel b.
  - Both counters saturate at 2^CNT_W−1.
- COMPARE, 1 cycle:
  - work[k] is set to (cnt_a > cnt_b).
  - ro_enable is driven to 0.
  - If k<RESP_BITS−1, k increments and the next state is SETUP; otherwise the next state is DONE.
- DONE, 1 cycle:
  - response is loaded from work.
  - done is driven to 1.
  - The next state is IDLE.
- start is ignored in every state other than IDLE, including DONE.
- challenge changes after acceptance have no effect.
- Equal counts, including both counters saturated, resolve the response bit to 0.
- If N_RO is odd, the pairs rotate through all channels via the modulo index.

## Timing
- Reset, applied at any clk edge while rst=0:
  - The FSM goes to IDLE, and k and base are cleared.
  - cnt_a and cnt_b are cleared, and the synchronizers are cleared to 0.
  - ro_enable, busy, done, response, work and tie are all driven to 0.
- Reset mid-operation aborts the measurement. The previous response is lost (forced to 0).
- When start is sampled at edge E in IDLE, busy=1 and state=SETUP from E+1.
- Each response bit costs WINDOW+5 cycles: 4 in SETUP, WINDOW in COUNT and 1 in COMPARE.
- done is high in the single cycle beginning at edge E + RESP_BITS·(WINDOW+5) + 1. response is updated at that same edge.
- busy falls one cycle after done, when the FSM returns to IDLE. A new start is accepted at the first IDLE edge.
- The input-to-count latency is 3 clk cycles. Oscillator frequencies must be below clk/2 for an exact count.

## Configuration
- ROPUF_TIE_DETECT_EN defined:
  - The tie port exists, and tie[k] is set to (cnt_a == cnt_b) in COMPARE for bit k.
  - tie is loaded together with response at DONE and is cleared by reset.
- ROPUF_TIE_DETECT_EN undefined: the tie port and its logic are absent. Behaviour is otherwise identical.

## Test plan
All scenarios use N_RO=8, WINDOW=64 and RESP_BITS=4. Bench oscillator models toggle with fixed periods.

- Reset check: hold rst=0 for 3 cycles with start=1. Required: busy=done=0, response=4'b0000, ro_enable=8'h00. No start is accepted.
- Challenge=0, with oscillators 0, 2, 4 and 6 at half-period 3 and oscillators 1, 3, 5 and 7 at half-period 5:
  - Required: response=4'b1111, with done exactly 4·69+1=277 cycles after the start edge.
  - Also required: during bit 1, ro_enable=8'b0000_1100.
- Wrap-around: challenge=7, with oscillator 7 faster than 0, 1 slower than 2, 3 faster than 4 and 5 slower than 6. Required: response=4'b0101, and ro_enable=8'b1000_0001 during bit 0.
- Handshake: pulse start during COUNT and again in the DONE cycle with a different challenge. Required: both are ignored, the first result is unchanged, busy=0 the cycle after done, and the next start is accepted.
- Reset mid-COUNT of bit 2. Required: next cycle busy=0, ro_enable=0, response=0, and no done pulse. A fresh start then completes normally.
- Tie, with ROPUF_TIE_DETECT_EN: oscillators 0 and 1 share an identical period. Required: response[0]=0 and tie[0]=1. Without the macro: response[0]=0 and there is no tie port.
